ahb_lite_master_bridge: RTL and testbench

Sits directly downstream of the multicycle ARM core's memory port (Adr / WriteData / MemWrite / ReadData) and turns each core access into a single AHB-Lite transfer. It sequences the address and data phases, honours HREADY wait states and two-cycle HRESP errors, and returns read data plus a completion pulse. The core's controller FSM stalls on `busy` until `done`. A watchdog aborts transfers whose slave never responds.

---
 rtl/ahb_lite_master_bridge.sv | 169 ++++++++++++++++
 tb/tb_ahb_lite_master_bridge.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master_bridge.sv
// Bridges the multicycle core memory port onto AHB-Lite, one SINGLE word transfer per access.
// err is registered: it carries the status of the latest done from the following cycle, alongside ReadData.
module ahb_lite_master_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter logic [3:0]  HPROT_VAL      = 4'b0011
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [31:0] Adr,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   output logic [31:0] ReadData,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] HADDR,
   output logic        HWRITE,
   output logic [1:0]  HTRANS,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   localparam int unsigned WD_W = 16;
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_ERR
   } state_t;

   state_t          state_q, state_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic [31:0]     haddr_q, haddr_d;
   logic            hwrite_q, hwrite_d;
   logic [1:0]      htrans_q, htrans_d;
   logic [31:0]     hwdata_q, hwdata_d;
   logic [31:0]     wdata_q, wdata_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            err_q, err_d;
   logic            done_c;
   logic            err_now_c;
   logic            timeout_c;
   logic            unused_ok;

   // Word-aligned bus: the byte offset bits of the core address carry no information here.
   assign unused_ok = ^Adr[1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         wd_q     <= '0;
         haddr_q  <= '0;
         hwrite_q <= 1'b0;
         htrans_q <= HTRANS_IDLE;
         hwdata_q <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wd_q     <= wd_d;
         haddr_q  <= haddr_d;
         hwrite_q <= hwrite_d;
         htrans_q <= htrans_d;
         hwdata_q <= hwdata_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      haddr_d   = haddr_q;
      hwrite_d  = hwrite_q;
      htrans_d  = htrans_q;
      hwdata_d  = hwdata_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      done_c    = 1'b0;
      err_now_c = 1'b0;

      // Watchdog fires on the stalled cycle that makes the run TIMEOUT_CYCLES long.
      timeout_c = (state_q != ST_IDLE) && !HREADY && (wd_q == WD_LIMIT);
      if ((state_q == ST_IDLE) || HREADY || timeout_c) begin
         wd_d = '0;
      end else begin
         wd_d = wd_q + WD_W'(1);
      end

      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               haddr_d  = {Adr[31:2], 2'b00};
               hwrite_d = MemWrite;
               wdata_d  = WriteData;
               htrans_d = HTRANS_NONSEQ;
               state_d  = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (HREADY) begin
               htrans_d = HTRANS_IDLE;
               hwdata_d = wdata_q;
               state_d  = ST_DATA;
            end
         end
         ST_DATA: begin
            if (HREADY) begin
               // A single-cycle ERROR is illegal AHB; it is still reported as an error completion.
               done_c    = 1'b1;
               err_now_c = HRESP;
               if (!HRESP && !hwrite_q) begin
                  rdata_d = HRDATA;
               end
               state_d = ST_IDLE;
            end else if (HRESP) begin
               state_d = ST_ERR;
            end
         end
         ST_ERR: begin
            if (HREADY) begin
               done_c    = 1'b1;
               err_now_c = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (timeout_c) begin
         done_c    = 1'b1;
         err_now_c = 1'b1;
         htrans_d  = HTRANS_IDLE;
         state_d   = ST_IDLE;
      end

      if (done_c) begin
         err_d = err_now_c;
      end
   end

   // A reset in the completing cycle aborts silently.
   assign done     = done_c && !reset;
   assign busy     = (state_q != ST_IDLE);
   assign err      = err_q;
   assign ReadData = rdata_q;
   assign HADDR    = haddr_q;
   assign HWRITE   = hwrite_q;
   assign HTRANS   = htrans_q;
   assign HWDATA   = hwdata_q;
   assign HSIZE    = 3'b010;
   assign HBURST   = 3'b000;
   assign HPROT    = HPROT_VAL;

endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// Scoreboard bench: the driver plays each access against a scripted slave and queues the expected
// completion; a negedge monitor pops and compares whenever done is seen.
module tb_ahb_lite_master_bridge;

   localparam int unsigned T = 6;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [31:0] Adr;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic [31:0] ReadData;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [3:0]  HPROT;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   ahb_lite_master_bridge #(.TIMEOUT_CYCLES(T), .HPROT_VAL(4'b0011)) dut (
      .clk(clk), .reset(reset), .req(req), .Adr(Adr), .WriteData(WriteData),
      .MemWrite(MemWrite), .ReadData(ReadData), .busy(busy), .done(done), .err(err),
      .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
      .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned done_cyc;
      int unsigned ns_cyc;
      logic [31:0] haddr;
      logic        hwrite;
      logic [31:0] hwdata;
      bit          chk_wdata;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   exp_t        sbq[$];
   int          pass_cnt = 0;
   int          tot_cnt  = 0;
   logic [31:0] rd_model = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt = tot_cnt + 1;
      if (act === exp) pass_cnt = pass_cnt + 1;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   // One core access: slave waits aw cycles in the address phase, dw in the data phase, then
   // answers OKAY or a two-cycle ERROR; any stall run reaching T ends in a watchdog abort.
   task automatic issue(input logic [31:0] adr, input logic [31:0] wd, input logic mw,
                        input int aw, input int dw, input bit er, input logic [31:0] rdv,
                        input int gap);
      logic hr[$];
      logic hp[$];
      exp_t e;
      bit   to;
      int   n;
      to = 1'b0;
      req = 1'b1; Adr = adr; WriteData = wd; MemWrite = mw;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
      if (aw >= int'(T)) begin
         repeat (T) begin hr.push_back(1'b0); hp.push_back(1'b0); end
         to = 1'b1;
      end else begin
         repeat (aw) begin hr.push_back(1'b0); hp.push_back(1'b0); end
         hr.push_back(1'b1); hp.push_back(1'b0);
         if (dw + (er ? 1 : 0) >= int'(T)) begin
            repeat (T) begin hr.push_back(1'b0); hp.push_back(1'b0); end
            to = 1'b1;
         end else begin
            repeat (dw) begin hr.push_back(1'b0); hp.push_back(1'b0); end
            if (er) begin
               hr.push_back(1'b0); hp.push_back(1'b1);
               hr.push_back(1'b1); hp.push_back(1'b1);
            end else begin
               hr.push_back(1'b1); hp.push_back(1'b0);
            end
         end
      end
      n = hr.size();
      e.done_cyc  = cyc + n;
      e.ns_cyc    = cyc + 1;
      e.haddr     = adr & 32'hFFFF_FFFC;
      e.hwrite    = mw;
      e.hwdata    = wd;
      e.chk_wdata = mw && (aw < int'(T));
      e.err       = to || er;
      if (!e.err && !mw) rd_model = rdv;
      e.rdata     = rd_model;
      sbq.push_back(e);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         HREADY = hr[i];
         HRESP  = hp[i];
         HRDATA = (i == n - 1) ? rdv : $urandom;
         // The core is stalled; wiggle its port to show the bridge ignores it while busy.
         if ($urandom_range(0, 2) == 0) begin
            req = 1'($urandom); Adr = $urandom; WriteData = $urandom; MemWrite = 1'($urandom);
         end
      end
      @(posedge clk); #1;
      req = 1'b0; HREADY = 1'($urandom); HRESP = 1'b0;
      repeat (gap) begin
         @(posedge clk); #1;
         HREADY = 1'($urandom); HRDATA = $urandom;
      end
   endtask

   // Monitor: captures the address phase, checks each completion and the cycle after it.
   bit          seen_ns = 1'b0;
   int unsigned obs_ns_cyc;
   logic [31:0] obs_haddr;
   logic        obs_hwrite;
   bit          pend = 1'b0;
   exp_t        cur;

   always @(negedge clk) begin
      if (pend) begin
         chk("rdata_after", ReadData, cur.rdata);
         chk("err_after", 32'(err), 32'(cur.err));
         chk("htrans_after", 32'(HTRANS), 32'd0);
         chk("busy_after", 32'(busy), 32'd0);
         pend = 1'b0;
      end
      if (reset) begin
         seen_ns = 1'b0;
      end else if (HTRANS === 2'b10 && !seen_ns) begin
         seen_ns    = 1'b1;
         obs_ns_cyc = cyc;
         obs_haddr  = HADDR;
         obs_hwrite = HWRITE;
      end
      if (done === 1'b1) begin
         if (sbq.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            cur = sbq.pop_front();
            chk("done_cycle", cyc, cur.done_cyc);
            chk("nonseq_cycle", obs_ns_cyc, cur.ns_cyc);
            chk("haddr", obs_haddr, cur.haddr);
            chk("hwrite", 32'(obs_hwrite), 32'(cur.hwrite));
            chk("busy_at_done", 32'(busy), 32'd1);
            if (cur.chk_wdata) chk("hwdata", HWDATA, cur.hwdata);
            pend = 1'b1;
         end
         seen_ns = 1'b0;
      end
   end

   initial begin
      reset = 1'b1; req = 1'b0; Adr = '0; WriteData = '0; MemWrite = 1'b0;
      HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_htrans", 32'(HTRANS), 32'd0);
      chk("rst_haddr", HADDR, 32'd0);
      chk("rst_hwdata", HWDATA, 32'd0);
      chk("rst_hwrite", 32'(HWRITE), 32'd0);
      chk("rst_rdata", ReadData, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("hsize", 32'(HSIZE), 32'd2);
      chk("hburst", 32'(HBURST), 32'd0);
      chk("hprot", 32'(HPROT), 32'd3);
      @(posedge clk); #1;
      reset = 1'b0;

      issue(32'h0000_0058, 32'h0, 1'b0, 0, 0, 1'b0, 32'h2FFF_FFFE, 1);
      issue(32'h0000_0060, 32'h7, 1'b1, 0, 2, 1'b0, 32'h1234_5678, 0);
      issue(32'h0000_0064, 32'h0, 1'b0, 0, 0, 1'b1, 32'hDEAD_BEEF, 0);
      issue(32'h0000_0070, 32'h9, 1'b1, int'(T), 0, 1'b0, 32'h0, 1);
      issue(32'h0000_0073, 32'h0, 1'b0, int'(T) - 1, 0, 1'b0, 32'hCAFE_0001, 0);
      issue(32'h0000_0080, 32'hA5A5, 1'b1, 1, int'(T) - 1, 1'b0, 32'h0, 0);
      issue(32'h0000_0084, 32'h0, 1'b0, 0, int'(T) - 2, 1'b1, 32'h0BAD_0000, 0);
      issue(32'h0000_0088, 32'h0, 1'b0, 0, int'(T) - 1, 1'b1, 32'h0BAD_0001, 2);
      issue(32'h0000_008C, 32'h0, 1'b0, 1, int'(T) - 1, 1'b0, 32'h600D_0001, 0);

      for (int k = 0; k < 150; k++) begin
         int aw;
         int dw;
         aw = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, T + 1));
         dw = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, T + 1));
         issue($urandom, $urandom, 1'($urandom), aw, dw, ($urandom_range(0, 3) == 0),
               $urandom, int'($urandom_range(0, 2)));
      end
      // Make sure the reset check below starts from non-zero load data.
      issue(32'h0000_0100, 32'h0, 1'b0, 0, 0, 1'b0, 32'h5555_AAAA, 1);

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

      // Reset in a stalled data phase: silent abort back to reset values.
      req = 1'b1; Adr = 32'h0000_0200; MemWrite = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
      @(posedge clk); #1;
      HREADY = 1'b1;
      @(posedge clk); #1;
      HREADY = 1'b0; req = 1'b0;
      @(negedge clk);
      chk("busy_in_data", 32'(busy), 32'd1);
      chk("no_done_stall", 32'(done), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("no_done_in_reset", 32'(done), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("mrst_htrans", 32'(HTRANS), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_rdata", ReadData, 32'd0);
      repeat (2) @(negedge clk);
      chk("mrst_still_idle", 32'(busy), 32'd0);
      chk("mrst_sb_empty", 32'(sbq.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
